// File: rtl/hamming_tx_scheduler_if.sv
// Request/acknowledge and serial line signals of the Hamming(12,8) transmit scheduler.
// master drives the requests; slave is the scheduler itself.
interface hamming_tx_scheduler_if;
  logic       reqA;
  logic [1:8] dataA;
  logic       ackA;
  logic       reqB;
  logic [1:8] dataB;
  logic       ackB;
  logic       txOut;
  logic       txValid;
  logic       frameStart;
  logic       busy;
  logic       lastGrant;

  modport master (
    output reqA, dataA, reqB, dataB,
    input  ackA, ackB, txOut, txValid, frameStart, busy, lastGrant
  );

  modport slave (
    input  reqA, dataA, reqB, dataB,
    output ackA, ackB, txOut, txValid, frameStart, busy, lastGrant
  );
endinterface

// File: rtl/hamming_tx_scheduler.sv
// Round-robin arbiter between two byte requesters that serialises the winner's byte as an
// even-parity Hamming(12,8) codeword, position 1 first, followed by GAP_CYCLES idle cycles.
module hamming_tx_scheduler #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input logic                    clk,
  input logic                    rst_n,
  hamming_tx_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StShift, StGap} stateT;

  localparam logic [3:0] GapLast = 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);

  // Codeword positions 1..12 = p1 p2 d1 p4 d2 d3 d4 p8 d5 d6 d7 d8, d1 = byte MSB.
  function automatic logic [1:12] encode(input logic [1:8] d);
    logic [1:12] c;
    c = {1'b0, 1'b0, d[1], 1'b0, d[2], d[3], d[4], 1'b0, d[5], d[6], d[7], d[8]};
    c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4] = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8] = c[9] ^ c[10] ^ c[11] ^ c[12];
    return c;
  endfunction

  stateT       stateQ, stateD;
  logic [3:0]  cntQ, cntD;
  logic [3:0]  gapQ, gapD;
  logic [1:12] shQ, shD;
  logic        lastGrantQ, lastGrantD;
  logic        ackAQ, ackAD;
  logic        ackBQ, ackBD;
  logic        txOutQ, txOutD;
  logic        txValidQ, txValidD;
  logic        frameStartQ, frameStartD;
  logic        busyQ, busyD;
  logic        pickB;
  logic [1:12] cw;

  always_comb begin
    stateD      = stateQ;
    cntD        = cntQ;
    gapD        = gapQ;
    shD         = shQ;
    lastGrantD  = lastGrantQ;
    ackAD       = 1'b0;
    ackBD       = 1'b0;
    txOutD      = 1'b0;
    txValidD    = 1'b0;
    frameStartD = 1'b0;
    pickB       = 1'b0;
    cw          = '0;

    unique case (stateQ)
      StIdle: begin
        if (bus.reqA || bus.reqB) begin
          // On a tie the requester that did not win last time gets the line.
          pickB       = bus.reqB && (!bus.reqA || !lastGrantQ);
          cw          = encode(pickB ? bus.dataB : bus.dataA);
          shD         = cw;
          lastGrantD  = pickB;
          ackAD       = !pickB;
          ackBD       = pickB;
          txOutD      = cw[1];
          txValidD    = 1'b1;
          frameStartD = 1'b1;
          cntD        = 4'd0;
          stateD      = StShift;
        end
      end
      StShift: begin
        if (cntQ == 4'd11) begin
          cntD = 4'd0;
          if (GAP_CYCLES > 0) begin
            gapD   = 4'd0;
            stateD = StGap;
          end else begin
            stateD = StIdle;
          end
        end else begin
          // shQ[1] is the bit on the line now, so shQ[2] goes out next.
          cntD     = cntQ + 4'd1;
          shD      = {shQ[2:12], 1'b0};
          txOutD   = shQ[2];
          txValidD = 1'b1;
        end
      end
      StGap: begin
        if (gapQ == GapLast) begin
          stateD = StIdle;
        end else begin
          gapD = gapQ + 4'd1;
        end
      end
      default: stateD = StIdle;
    endcase

    busyD = (stateD != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ      <= StIdle;
      cntQ        <= 4'd0;
      gapQ        <= 4'd0;
      shQ         <= '0;
      lastGrantQ  <= 1'b1;
      ackAQ       <= 1'b0;
      ackBQ       <= 1'b0;
      txOutQ      <= 1'b0;
      txValidQ    <= 1'b0;
      frameStartQ <= 1'b0;
      busyQ       <= 1'b0;
    end else begin
      stateQ      <= stateD;
      cntQ        <= cntD;
      gapQ        <= gapD;
      shQ         <= shD;
      lastGrantQ  <= lastGrantD;
      ackAQ       <= ackAD;
      ackBQ       <= ackBD;
      txOutQ      <= txOutD;
      txValidQ    <= txValidD;
      frameStartQ <= frameStartD;
      busyQ       <= busyD;
    end
  end

  assign bus.ackA       = ackAQ;
  assign bus.ackB       = ackBQ;
  assign bus.txOut      = txOutQ;
  assign bus.txValid    = txValidQ;
  assign bus.frameStart = frameStartQ;
  assign bus.busy       = busyQ;
  assign bus.lastGrant  = lastGrantQ;

endmodule

// File: doc/hamming_tx_scheduler.md
HAMMING_TX_SCHEDULER -- requirements
Module: hamming_tx_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 1: idle line cycles (0..15) inserted after each frame.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port reqA, input, 1: requester A has a byte pending.
REQ-005 SHALL have port dataA, input, [1:8]: requester A byte, bit 1 = MSB.
REQ-006 SHALL have port ackA, output, 1: one-cycle pulse, A's byte accepted.
REQ-007 SHALL have ports reqB, input, 1; dataB, input, [1:8]; ackB, output, 1: requester B, identical semantics to A.
REQ-008 SHALL have port txOut, output, 1: serial codeword bit.
REQ-009 SHALL have port txValid, output, 1: txOut carries a codeword bit.
REQ-010 SHALL have port frameStart, output, 1: high with first bit of each frame.
REQ-011 SHALL have port busy, output, 1: FSM not in IDLE.
REQ-012 SHALL have port lastGrant, output, 1: 0 = A granted last, 1 = B granted last.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, GAP; all outputs registered.
REQ-014 SHALL, in IDLE with only one req high at an edge, grant that requester.
REQ-015 SHALL, in IDLE with both reqs high, grant the requester not equal to lastGrant (round-robin).
REQ-016 SHALL, on grant edge: latch the winner's byte, encode it into a 12-bit shift register, set lastGrant, pulse that requester's ack for exactly the following cycle, enter SHIFT with bit counter 0.
REQ-017 SHALL encode with even-parity Hamming(12,8): positions 1..12 = p1 p2 d1 p4 d2 d3 d4 p8 d5 d6 d7 d8.
REQ-018 SHALL compute p1 = xor(pos 3,5,7,9,11), p2 = xor(3,6,7,10,11), p4 = xor(5,6,7,12), p8 = xor(9,10,11,12).
REQ-019 SHALL, in SHIFT, drive txValid=1 and txOut = codeword position 1+count, count 0..11, position 1 first.
REQ-020 SHALL assert frameStart only during count 0.
REQ-021 SHALL, after count 11, enter GAP if GAP_CYCLES>0, else IDLE.
REQ-022 SHALL, in GAP, hold txValid=0 and txOut=0 for GAP_CYCLES cycles, then enter IDLE.
REQ-023 SHALL ignore reqA/reqB and dataA/dataB outside IDLE; a req still high on return to IDLE is a new request.
REQ-024 SHALL achieve a back-to-back frame period of 13+GAP_CYCLES cycles between frameStart pulses under continuous requests.
REQ-025 SHALL assert busy in SHIFT and GAP, deassert in IDLE.
REQ-026 SHALL drive txOut=0, txValid=0, frameStart=0 whenever not in SHIFT.

Reset
REQ-027 SHALL, on rst_n low, immediately (no clock) force IDLE, counters 0, shift register 0, ackA=ackB=txOut=txValid=frameStart=busy=0, lastGrant=1 (A wins first tie).
REQ-028 SHALL, on reset mid-frame, abort the frame with no re-send and no further ack for the aborted byte.
REQ-029 SHALL leave IDLE no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-030 SHALL verify: reqA=1, dataA=00111011 -> ackA one cycle; bits 1,1,0,1,0,1,1,1,1,0,1,1 over 12 cycles; frameStart on first only.
REQ-031 SHALL verify: reqB=1, dataB=01001001 -> ackB; serial 000010001001; lastGrant=1.
REQ-032 SHALL verify: after reset, reqA=reqB=1 held continuously (GAP_CYCLES=1) -> grants A,B,A,B; frameStart spacing 14 cycles.
REQ-033 SHALL verify: GAP_CYCLES=0 with continuous reqA -> frameStart spacing 13 cycles; txValid low exactly 1 cycle between frames.
REQ-034 SHALL verify: rst_n low at bit 5 of a frame -> txValid, busy drop same time step; after release, no ack or output until a new req.
REQ-035 SHALL verify: dataA changes during SHIFT -> transmitted codeword unchanged (encoding of latched byte, e.g. 10000100 -> 101000010100).
